l2_bank_resp_adapter: RTL and testbench
=======================================

Name: l2_bank_resp_adapter

Overview:
- Bank-side endpoint directly downstream of the L2 request fan-in tree (the 2:1 request fan-in primitives).
- Consumes the single winning request and generates the round-robin priority flags that steer the tree.
- Drives one single-cycle L2 SRAM macro and returns each response with the originating ID, so the response crossbar can route it.

Parameters:
- ADDR_WIDTH, 32, request byte-address width
- ID_WIDTH, 16, transaction ID width
- DATA_WIDTH, 64, data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- BANK_ADDR_WIDTH, 12, SRAM word-address width
- N_RR_BITS, 3, RR flag width, one bit per fan-in tree level
- ADDR_LSB, log2(BE_WIDTH), first word-address bit in data_add_i

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_req_i  in  1  request from fan-in tree root
- data_add_i  in  ADDR_WIDTH  byte address
- data_wen_i  in  1  1=read, 0=write
- data_wdata_i  in  DATA_WIDTH  write data
- data_be_i  in  BE_WIDTH  byte enables
- data_ID_i  in  ID_WIDTH  transaction ID
- data_gnt_o  out  1  grant to tree root
- rr_flag_o  out  N_RR_BITS  round-robin flags to tree levels (bit k drives level k)
- stall_i  in  1  bank blocked (refresh/BIST); no accept while high
- mem_cen_o  out  1  SRAM chip enable, active low
- mem_wen_o  out  1  SRAM write enable, active low
- mem_addr_o  out  BANK_ADDR_WIDTH  SRAM word address
- mem_wdata_o  out  DATA_WIDTH  SRAM write data
- mem_be_o  out  BE_WIDTH  SRAM byte enables
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid 1 cycle after CEN low
- data_r_valid_o  out  1  response valid
- data_r_ID_o  out  ID_WIDTH  response ID
- data_r_rdata_o  out  DATA_WIDTH  response read data

Behaviour:
- data_gnt_o = ~stall_i. It must not depend on data_req_i; this keeps the tree gnt/req path free of combinational loops.
- accept = data_req_i & ~stall_i.
- SRAM drive, all combinational from inputs:
  - mem_cen_o = ~accept
  - mem_wen_o = data_wen_i | ~accept
  - mem_addr_o = data_add_i[ADDR_LSB +: BANK_ADDR_WIDTH]; upper address bits are ignored
  - mem_wdata_o = data_wdata_i; mem_be_o = data_be_i
- Response pipeline (registers: valid_q, id_q, rd_q):
  - On accept: valid_q<=1, id_q<=data_ID_i, rd_q<=data_wen_i.
  - Otherwise: valid_q<=0; id_q and rd_q hold.
- Response outputs:
  - data_r_valid_o=valid_q; data_r_ID_o=id_q.
  - data_r_rdata_o = rd_q ? mem_rdata_i : 0.
  - Latency is exactly 1 cycle. Writes also produce a response (r_valid with zero data).
  - No response backpressure. Back-to-back accepts give back-to-back responses, one per cycle.
- RR counter:
  - N_RR_BITS-bit register rr_q; rr_flag_o = rr_q.
  - Increments by 1 on every accept and wraps from 2^N_RR_BITS-1 to 0.
  - Holds when there is no accept, including while stall_i is high.
- Simultaneous stall_i and data_req_i: no accept, mem_cen_o=1, no response next cycle, rr holds.
- Reset values:
  - valid_q=0, id_q=0, rd_q=0, rr_q=0.
  - Hence data_r_valid_o=0, data_r_ID_o=0, data_r_rdata_o=0, rr_flag_o=0.
  - mem_cen_o=1 whenever data_req_i=0.
- Reset asserted mid-operation drops any pending response; no r_valid is emitted for it.

Optional Feature:
- Macro: L2_BANK_RDATA_REG_EN.
- When defined: a second register stage captures valid, ID and the muxed rdata. Response latency becomes 2 cycles and throughput stays 1 per cycle. Stage-2 registers reset to 0.
- When undefined: 1-cycle latency as above.
- rr_flag_o and SRAM timing are identical in both builds.

Decomposition:
- Shared package l2_xbar_pkg holds:
  - default widths: ADDR_WIDTH, ID_WIDTH, DATA_WIDTH, BANK_ADDR_WIDTH, N_RR_BITS
  - localparam BE_WIDTH and ADDR_LSB derivation
  - the read/write encoding constant for wen (READ=1)
- One natural sub-module: l2_rr_counter, the N_RR_BITS wrap counter with enable and async active-low reset. It is reusable by other tree roots.

Test Plan:
- Reset then idle → rr_flag_o=0, data_r_valid_o=0, mem_cen_o=1 for 10 cycles.
- Write: req=1, wen=0, add=0x0000_0040, wdata=0xDEADBEEF_CAFEF00D, be=0xFF, ID=0x0005 → same cycle: mem_cen_o=0, mem_wen_o=0, mem_addr_o=0x008. Next cycle: r_valid=1, r_ID=0x0005, r_rdata=0. rr_flag_o goes 0→1.
- Read back to back: reads of 0x040 (ID 3) and 0x048 (ID 4), with the SRAM model returning the stored words → responses on consecutive cycles with IDs 3 then 4 and the correct data. rr advances by 2.
- Wrap: 8 consecutive accepts with N_RR_BITS=3 → rr_flag_o steps 1..7 then 0.
- Stall: stall_i=1 with req=1 for 3 cycles → data_gnt_o=0, mem_cen_o=1, no r_valid, rr holds. The request is accepted the cycle stall_i drops.
- Reset mid-flight: assert rst_n=0 in the cycle after an accept → r_valid stays 0 and rr_flag_o=0. With L2_BANK_RDATA_REG_EN defined, rerun the read test → responses arrive 2 cycles after accept.

Source files
------------

// File: rtl/l2_xbar_pkg.sv
// Shared L2 crossbar definitions: default bus widths, derived byte-enable
// width and word-address offset, and the wen read/write encoding.
package l2_xbar_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int ID_WIDTH        = 16;
  localparam int DATA_WIDTH      = 64;
  localparam int BANK_ADDR_WIDTH = 12;
  localparam int N_RR_BITS       = 3;

  // One byte enable per data byte; word address starts above the byte offset.
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(BE_WIDTH);

  // Request wen encoding as seen on the fan-in tree (read is high).
  typedef enum logic {
    WEN_WRITE = 1'b0,
    WEN_READ  = 1'b1
  } wen_e;

endpackage

// File: rtl/l2_bank_resp_adapter_if.sv
// Bank-side bundle: request from the fan-in tree root, RR flags back to the
// tree, SRAM macro drive and the response towards the response crossbar.
// Signal suffixes are named from the adapter's point of view.
interface l2_bank_resp_adapter_if #(
  parameter int ADDR_WIDTH      = l2_xbar_pkg::ADDR_WIDTH,
  parameter int ID_WIDTH        = l2_xbar_pkg::ID_WIDTH,
  parameter int DATA_WIDTH      = l2_xbar_pkg::DATA_WIDTH,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int BANK_ADDR_WIDTH = l2_xbar_pkg::BANK_ADDR_WIDTH,
  parameter int N_RR_BITS       = l2_xbar_pkg::N_RR_BITS
);

  // request side
  logic                       data_req_i;
  logic [ADDR_WIDTH-1:0]      data_add_i;
  logic                       data_wen_i;
  logic [DATA_WIDTH-1:0]      data_wdata_i;
  logic [BE_WIDTH-1:0]        data_be_i;
  logic [ID_WIDTH-1:0]        data_ID_i;
  logic                       data_gnt_o;
  logic [N_RR_BITS-1:0]       rr_flag_o;
  logic                       stall_i;
  // SRAM macro
  logic                       mem_cen_o;
  logic                       mem_wen_o;
  logic [BANK_ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0]      mem_wdata_o;
  logic [BE_WIDTH-1:0]        mem_be_o;
  logic [DATA_WIDTH-1:0]      mem_rdata_i;
  // response side
  logic                       data_r_valid_o;
  logic [ID_WIDTH-1:0]        data_r_ID_o;
  logic [DATA_WIDTH-1:0]      data_r_rdata_o;

  // Adapter side.
  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
           data_ID_i, stall_i, mem_rdata_i,
    output data_gnt_o, rr_flag_o, mem_cen_o, mem_wen_o, mem_addr_o,
           mem_wdata_o, mem_be_o, data_r_valid_o, data_r_ID_o, data_r_rdata_o
  );

  // Tree root / SRAM / response crossbar side.
  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
           data_ID_i, stall_i, mem_rdata_i,
    input  data_gnt_o, rr_flag_o, mem_cen_o, mem_wen_o, mem_addr_o,
           mem_wdata_o, mem_be_o, data_r_valid_o, data_r_ID_o, data_r_rdata_o
  );

endinterface

// File: rtl/l2_rr_counter.sv
// Round-robin priority counter for a fan-in tree root: advances by one on
// every enable and wraps naturally at 2^WIDTH.
module l2_rr_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count enabled events; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/l2_bank_resp_adapter.sv
// L2 bank endpoint: accepts the winning request from the fan-in tree, drives
// a single-cycle SRAM macro and returns each response tagged with its ID.
// Define L2_BANK_RDATA_REG_EN to add a registered response stage
// (2-cycle response latency, full throughput).
module l2_bank_resp_adapter
  import l2_xbar_pkg::*;
#(
  parameter int ADDR_WIDTH      = l2_xbar_pkg::ADDR_WIDTH,
  parameter int ID_WIDTH        = l2_xbar_pkg::ID_WIDTH,
  parameter int DATA_WIDTH      = l2_xbar_pkg::DATA_WIDTH,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int BANK_ADDR_WIDTH = l2_xbar_pkg::BANK_ADDR_WIDTH,
  parameter int N_RR_BITS       = l2_xbar_pkg::N_RR_BITS,
  parameter int ADDR_LSB        = $clog2(BE_WIDTH)
) (
  input logic                      clk,
  input logic                      rst_n,
  l2_bank_resp_adapter_if.slave    bus
);

  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [N_RR_BITS-1:0]  w_rr;
  logic                  w_unused_addr;

  logic                  r_valid_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  wen_e                  r_rd_q;

  // Grant depends on stall only, never on req, so the tree has no gnt/req loop.
  assign bus.data_gnt_o = ~bus.stall_i;
  assign w_accept       = bus.data_req_i & ~bus.stall_i;

  // SRAM drive straight from the request; bits outside the bank word index
  // were already consumed by bank selection upstream.
  assign bus.mem_cen_o   = ~w_accept;
  assign bus.mem_wen_o   = bus.data_wen_i | ~w_accept;
  assign bus.mem_addr_o  = bus.data_add_i[ADDR_LSB +: BANK_ADDR_WIDTH];
  assign bus.mem_wdata_o = bus.data_wdata_i;
  assign bus.mem_be_o    = bus.data_be_i;
  assign w_unused_addr   = ^{bus.data_add_i[ADDR_WIDTH-1:ADDR_LSB+BANK_ADDR_WIDTH],
                             bus.data_add_i[ADDR_LSB-1:0]};

  // Track the accepted transaction alongside the SRAM access cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
      r_rd_q    <= WEN_WRITE;
    end else begin
      r_valid_q <= w_accept;
      if (w_accept) begin
        r_id_q <= bus.data_ID_i;
        r_rd_q <= wen_e'(bus.data_wen_i);
      end
    end
  end

  // Writes return zero data; reads pass the SRAM output through, per lane.
  for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
    assign w_rdata[gi*8 +: 8] = (r_rd_q == WEN_READ) ? bus.mem_rdata_i[gi*8 +: 8] : 8'h00;
  end

`ifdef L2_BANK_RDATA_REG_EN
  logic                  r_valid_q2;
  logic [ID_WIDTH-1:0]   r_id_q2;
  logic [DATA_WIDTH-1:0] r_rdata_q2;

  // Extra response stage to ease timing from the SRAM output into the crossbar.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q2 <= 1'b0;
      r_id_q2    <= '0;
      r_rdata_q2 <= '0;
    end else begin
      r_valid_q2 <= r_valid_q;
      r_id_q2    <= r_id_q;
      r_rdata_q2 <= w_rdata;
    end
  end

  assign bus.data_r_valid_o = r_valid_q2;
  assign bus.data_r_ID_o    = r_id_q2;
  assign bus.data_r_rdata_o = r_rdata_q2;
`else
  assign bus.data_r_valid_o = r_valid_q;
  assign bus.data_r_ID_o    = r_id_q;
  assign bus.data_r_rdata_o = w_rdata;
`endif

  // Priority rotates once per accepted request.
  l2_rr_counter #(
    .WIDTH (N_RR_BITS)
  ) u_rr_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_accept),
    .o_count (w_rr)
  );

  assign bus.rr_flag_o = w_rr;

endmodule

// File: tb/tb_l2_bank_resp_adapter.sv
// Self-checking bench for l2_bank_resp_adapter: directed steps followed by
// random traffic, checked against a transaction-level reference model.
module tb_l2_bank_resp_adapter;

`ifdef L2_BANK_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          due;
    logic [15:0] id;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_bank_resp_adapter_if bus ();

  l2_bank_resp_adapter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Byte-enable merge of new data into an old word.
  function automatic logic [63:0] be_merge(input logic [63:0] old_w,
                                           input logic [63:0] new_w,
                                           input logic [7:0] be);
    logic [63:0] r;
    r = old_w;
    for (int b = 0; b < 8; b++)
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Behavioural single-cycle SRAM macro.
  logic [63:0] sram [0:4095];
  always @(posedge clk) begin
    if (!bus.mem_cen_o) begin
      if (!bus.mem_wen_o)
        sram[bus.mem_addr_o] <= be_merge(sram[bus.mem_addr_o], bus.mem_wdata_o, bus.mem_be_o);
      else
        bus.mem_rdata_i <= sram[bus.mem_addr_o];
    end
  end

  // Reference model state.
  logic [63:0] ref_mem [0:4095];
  exp_t        exp_q[$];
  int          accepts;
  int          cyc;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+2, advance.
  task automatic step(input logic req, input logic stall, input logic wen,
                      input logic [31:0] add, input logic [63:0] wd,
                      input logic [7:0] be, input logic [15:0] id);
    logic        acc;
    logic [11:0] waddr;
    exp_t        e;
    bit          exp_valid;
    bus.data_req_i   = req;
    bus.stall_i      = stall;
    bus.data_wen_i   = wen;
    bus.data_add_i   = add;
    bus.data_wdata_i = wd;
    bus.data_be_i    = be;
    bus.data_ID_i    = id;
    #1;
    acc   = req && !stall;
    waddr = 12'((add / 8) % 4096);
    chk("gnt", 64'(bus.data_gnt_o), 64'(!stall));
    chk("cen", 64'(bus.mem_cen_o), 64'(!acc));
    chk("mwen", 64'(bus.mem_wen_o), 64'(wen || !acc));
    if (acc) begin
      chk("maddr", 64'(bus.mem_addr_o), 64'(waddr));
      chk("mwdata", bus.mem_wdata_o, wd);
      chk("mbe", 64'(bus.mem_be_o), 64'(be));
    end
    exp_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("r_valid", 64'(bus.data_r_valid_o), 64'(exp_valid));
    if (exp_valid) begin
      e = exp_q.pop_front();
      chk("r_id", 64'(bus.data_r_ID_o), 64'(e.id));
      chk("r_rdata", bus.data_r_rdata_o, e.data);
      $display("resp cyc=%0d id=%h rdata=%h", cyc, bus.data_r_ID_o, bus.data_r_rdata_o);
    end
    chk("rr", 64'(bus.rr_flag_o), 64'(accepts % 8));
    if (acc) begin
      e.due  = cyc + LAT;
      e.id   = id;
      e.data = wen ? ref_mem[waddr] : 64'h0;
      if (!wen) ref_mem[waddr] = be_merge(ref_mem[waddr], wd, be);
      exp_q.push_back(e);
      accepts++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b1, 32'h0, 64'h0, 8'h00, 16'h0);
  endtask

  task automatic rand_step(input int stall_pct);
    logic [31:0] a;
    a = {$urandom_range(0, 32'h0007_ffff), $urandom_range(0, 15), $urandom_range(0, 7)} ;
    step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) < stall_pct),
         1'($urandom_range(0, 1)), {a[31:7] ^ 25'($urandom), a[6:0]},
         {$urandom, $urandom}, 8'($urandom), 16'($urandom));
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    accepts = 0;
    for (int i = 0; i < 4096; i++) begin
      sram[i] = 64'h0;
      ref_mem[i] = 64'h0;
    end
    bus.data_req_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.data_wen_i = 1'b1;
    bus.data_add_i = '0;
    bus.data_wdata_i = '0;
    bus.data_be_i = '0;
    bus.data_ID_i = '0;

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.data_r_valid_o), 64'h0);
    chk("rst_id", 64'(bus.data_r_ID_o), 64'h0);
    chk("rst_rdata", bus.data_r_rdata_o, 64'h0);
    chk("rst_rr", 64'(bus.rr_flag_o), 64'h0);
    chk("rst_cen", 64'(bus.mem_cen_o), 64'h1);
    rst_n = 1'b1;

    // Idle after reset.
    repeat (10) idle();

    // Write, then read it back-to-back with a second word.
    step(1'b1, 1'b0, 1'b0, 32'h0000_0040, 64'hDEADBEEF_CAFEF00D, 8'hFF, 16'h0005);
    chk("rr_after_write", 64'(bus.rr_flag_o), 64'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0000_0048, 64'h0123_4567_89AB_CDEF, 8'h0F, 16'h0006);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040, 64'h0, 8'hFF, 16'h0003);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0048, 64'h0, 8'hFF, 16'h0004);
    repeat (3) idle();
    chk("rr_after_reads", 64'(bus.rr_flag_o), 64'h4);

    // Eight accepts walk rr through a full wrap.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 1'b1, 32'(i * 8), 64'h0, 8'hFF, 16'(16'h0100 + i));
    chk("rr_wrap", 64'(bus.rr_flag_o), 64'h4);
    repeat (2) idle();

    // Stall with a pending request, then accept as stall drops.
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0000_0080, 64'h5555_AAAA_5555_AAAA, 8'hFF, 16'h0077);
    step(1'b1, 1'b0, 1'b0, 32'h0000_0080, 64'h5555_AAAA_5555_AAAA, 8'hFF, 16'h0077);
    step(1'b1, 1'b0, 1'b1, 32'hFFF0_0080, 64'h0, 8'hFF, 16'h0078);
    repeat (2) idle();

    // Random traffic.
    repeat (400) rand_step(25);
    repeat (3) idle();

    // Reset one cycle after an accept: the pending response is dropped.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040, 64'h0, 8'hFF, 16'h0099);
    bus.data_req_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.data_r_valid_o), 64'h0);
    chk("midrst_rr", 64'(bus.rr_flag_o), 64'h0);
    exp_q.delete();
    accepts = 0;
    @(posedge clk);
    #1;
    chk("midrst_valid2", 64'(bus.data_r_valid_o), 64'h0);
    cyc++;
    rst_n = 1'b1;
    repeat (3) idle();

    // More random traffic, then drain.
    repeat (150) rand_step(10);
    repeat (LAT + 2) idle();
    chk("drain", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
